// File: rtl/xlr_mem_pkg.sv
// Shared line/byte-enable types, host operation encoding and per-byte parity helper
// for the accelerator banked line memory.
package xlr_mem_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned BE_W   = LINE_W / 8;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BE_W-1:0]   be_t;

  typedef enum logic {
    HOST_RD = 1'b0,
    HOST_WR = 1'b1
  } host_op_e;

  // Even parity: stored bit makes the byte plus parity carry an even count of ones.
  function automatic be_t line_parity(input line_t line);
    be_t p;
    p = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      p[i] = ^line[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/xlr_mem_bank_ram.sv
// One memory bank: byte-enabled accelerator port with registered read-first read,
// and a full-line host port with combinational read. Optional parity: XLR_MEM_PARITY_EN.
module xlr_mem_bank_ram
  import xlr_mem_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_rd,
  input  logic              i_a_wr,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [LINE_W-1:0] i_a_wdata,
  input  logic [BE_W-1:0]   i_a_be,
  output logic [LINE_W-1:0] o_a_rdata,
  input  logic              i_b_we,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [LINE_W-1:0] i_b_wdata,
  output logic [LINE_W-1:0] o_b_rdata
`ifdef XLR_MEM_PARITY_EN
  ,
  output logic              o_a_perr,
  output logic              o_b_perr
`endif
);

  localparam int unsigned LINES = 1 << AW;

  line_t r_mem [LINES];
  line_t r_a_rdata;

  // Host writes only land when the accelerator leaves this bank idle.
  always_ff @(posedge clk) begin
    if (i_a_wr) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (i_a_be[i]) begin
          r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
        end
      end
    end else if (i_b_we) begin
      r_mem[i_b_addr] <= i_b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rdata <= '0;
    end else if (i_a_rd) begin
      r_a_rdata <= r_mem[i_a_addr];
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_mem[i_b_addr];

`ifdef XLR_MEM_PARITY_EN
  be_t  r_par [LINES];
  logic r_a_perr;

  always_ff @(posedge clk) begin
    if (i_a_wr) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (i_a_be[i]) begin
          r_par[i_a_addr][i] <= ^i_a_wdata[8*i +: 8];
        end
      end
    end else if (i_b_we) begin
      r_par[i_b_addr] <= line_parity(i_b_wdata);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_perr <= 1'b0;
    end else begin
      r_a_perr <= i_a_rd && (line_parity(r_mem[i_a_addr]) != r_par[i_a_addr]);
    end
  end

  assign o_a_perr = r_a_perr;
  assign o_b_perr = (line_parity(o_b_rdata) != r_par[i_b_addr]);
`endif

endmodule

// File: rtl/xlr_mem_bank.sv
// Banked line memory beside an accelerator: NUM_MEMS banks, never-stalled accelerator
// port, lower-priority host port arbitrated per bank. Optional parity: XLR_MEM_PARITY_EN.
module xlr_mem_bank
  import xlr_mem_pkg::*;
#(
  parameter  int unsigned NUM_MEMS           = 1,
  parameter  int unsigned LOG2_LINES_PER_MEM = 4,
  localparam int unsigned SEL_W              = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
  input  logic [NUM_MEMS*256-1:0]            xlr_mem_wdata,
  input  logic [NUM_MEMS*32-1:0]             xlr_mem_be,
  input  logic [NUM_MEMS-1:0]                xlr_mem_rd,
  input  logic [NUM_MEMS-1:0]                xlr_mem_wr,
  output logic [NUM_MEMS*256-1:0]            xlr_mem_rdata,
  input  logic                               host_mem_req,
  input  logic                               host_mem_we,
  input  logic [SEL_W-1:0]                   host_mem_sel,
  input  logic [LOG2_LINES_PER_MEM-1:0]      host_mem_addr,
  input  logic [255:0]                       host_mem_wdata,
  output logic                               host_mem_gnt,
  output logic [255:0]                       host_mem_rdata,
  output logic                               host_mem_rvalid
`ifdef XLR_MEM_PARITY_EN
  ,
  output logic [NUM_MEMS:0]                  parity_err
`endif
);

  localparam int unsigned AW = LOG2_LINES_PER_MEM;

  logic [NUM_MEMS-1:0] w_busy;
  logic [NUM_MEMS-1:0] w_b_we;
  line_t               w_b_rdata [NUM_MEMS];
  logic                w_sel_busy;
  logic                w_gnt;
  logic                w_host_rd_go;
  host_op_e            w_op;
  line_t               w_host_rd;
  line_t               r_host_rdata;
  logic                r_host_rvalid;

  assign w_busy = xlr_mem_rd | xlr_mem_wr;
  assign w_op   = host_op_e'(host_mem_we);

  // An out-of-range select matches no bank: never busy, reads back zero.
  always_comb begin
    w_sel_busy = 1'b0;
    w_host_rd  = '0;
    for (int unsigned m = 0; m < NUM_MEMS; m++) begin
      if (host_mem_sel == SEL_W'(m)) begin
        w_sel_busy = w_busy[m];
        w_host_rd  = w_b_rdata[m];
      end
    end
  end

  assign w_gnt        = host_mem_req && !w_sel_busy && !rst;
  assign w_host_rd_go = w_gnt && (w_op == HOST_RD);
  assign host_mem_gnt = w_gnt;

`ifdef XLR_MEM_PARITY_EN
  logic [NUM_MEMS-1:0] w_a_perr;
  logic [NUM_MEMS-1:0] w_b_perr;
  logic                w_host_perr;
  logic                r_host_perr;
`endif

  for (genvar m = 0; m < NUM_MEMS; m++) begin : g_mem
    assign w_b_we[m] = w_gnt && (w_op == HOST_WR) && (host_mem_sel == SEL_W'(m));

    xlr_mem_bank_ram #(
      .AW (AW)
    ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_a_rd    (xlr_mem_rd[m]),
      .i_a_wr    (xlr_mem_wr[m]),
      .i_a_addr  (xlr_mem_addr[m*AW +: AW]),
      .i_a_wdata (xlr_mem_wdata[m*LINE_W +: LINE_W]),
      .i_a_be    (xlr_mem_be[m*BE_W +: BE_W]),
      .o_a_rdata (xlr_mem_rdata[m*LINE_W +: LINE_W]),
      .i_b_we    (w_b_we[m]),
      .i_b_addr  (host_mem_addr),
      .i_b_wdata (host_mem_wdata),
      .o_b_rdata (w_b_rdata[m])
`ifdef XLR_MEM_PARITY_EN
      ,
      .o_a_perr  (w_a_perr[m]),
      .o_b_perr  (w_b_perr[m])
`endif
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_host_rvalid <= w_host_rd_go;
      if (w_host_rd_go) begin
        r_host_rdata <= w_host_rd;
      end
    end
  end

  assign host_mem_rdata  = r_host_rdata;
  assign host_mem_rvalid = r_host_rvalid;

`ifdef XLR_MEM_PARITY_EN
  always_comb begin
    w_host_perr = 1'b0;
    for (int unsigned m = 0; m < NUM_MEMS; m++) begin
      if (host_mem_sel == SEL_W'(m)) begin
        w_host_perr = w_b_perr[m];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_host_perr <= 1'b0;
    end else begin
      r_host_perr <= w_host_rd_go && w_host_perr;
    end
  end

  assign parity_err = {r_host_perr, w_a_perr};
`endif

endmodule

// File: tb/tb_xlr_mem_bank.sv
// Scoreboard bench for xlr_mem_bank: directed accelerator/host traffic, expected read
// data queued at issue time and checked by an independent negedge monitor.
module tb_xlr_mem_bank;
  import xlr_mem_pkg::*;

  localparam int unsigned NM = 1;
  localparam int unsigned AW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NM*AW-1:0]   xlr_mem_addr;
  logic [NM*256-1:0]  xlr_mem_wdata;
  logic [NM*32-1:0]   xlr_mem_be;
  logic [NM-1:0]      xlr_mem_rd;
  logic [NM-1:0]      xlr_mem_wr;
  logic [NM*256-1:0]  xlr_mem_rdata;
  logic               host_mem_req;
  logic               host_mem_we;
  logic [0:0]         host_mem_sel;
  logic [AW-1:0]      host_mem_addr;
  logic [255:0]       host_mem_wdata;
  logic               host_mem_gnt;
  logic [255:0]       host_mem_rdata;
  logic               host_mem_rvalid;
`ifdef XLR_MEM_PARITY_EN
  logic [NM:0]        parity_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] xq[$];
  logic [255:0] hq[$];
  logic xlr_pend   = 1'b0;
  logic host_pend  = 1'b0;
  logic host_issue = 1'b0;

  xlr_mem_bank #(
    .NUM_MEMS           (NM),
    .LOG2_LINES_PER_MEM (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .xlr_mem_addr    (xlr_mem_addr),
    .xlr_mem_wdata   (xlr_mem_wdata),
    .xlr_mem_be      (xlr_mem_be),
    .xlr_mem_rd      (xlr_mem_rd),
    .xlr_mem_wr      (xlr_mem_wr),
    .xlr_mem_rdata   (xlr_mem_rdata),
    .host_mem_req    (host_mem_req),
    .host_mem_we     (host_mem_we),
    .host_mem_sel    (host_mem_sel),
    .host_mem_addr   (host_mem_addr),
    .host_mem_wdata  (host_mem_wdata),
    .host_mem_gnt    (host_mem_gnt),
    .host_mem_rdata  (host_mem_rdata),
    .host_mem_rvalid (host_mem_rvalid)
`ifdef XLR_MEM_PARITY_EN
    ,
    .parity_err      (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s: DUT output present, expected nothing outstanding", name);
  endtask

  // Track which cycles the bench itself expects read data in.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xlr_pend  <= 1'b0;
      host_pend <= 1'b0;
    end else begin
      xlr_pend  <= xlr_mem_rd[0];
      host_pend <= host_issue;
    end
  end

  always @(negedge clk) begin
    if (xlr_pend) begin
      if (xq.size() == 0) note_fail("xlr_unexpected_read");
      else check("xlr_rdata", xlr_mem_rdata[255:0], xq.pop_front());
    end
    check("host_rvalid", {255'd0, host_mem_rvalid}, {255'd0, host_pend});
    if (host_mem_rvalid) begin
      if (hq.size() == 0) note_fail("host_unexpected_rvalid");
      else check("host_rdata", host_mem_rdata, hq.pop_front());
    end
  end

  task automatic xlr_cycle(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [255:0] wd, input logic [31:0] be,
                           input logic [255:0] exp);
    xlr_mem_rd[0] = rd;
    xlr_mem_wr[0] = wr;
    xlr_mem_addr  = a;
    xlr_mem_wdata = wd;
    xlr_mem_be    = be;
    if (rd) xq.push_back(exp);
    @(posedge clk);
    #1;
    xlr_mem_rd = '0;
    xlr_mem_wr = '0;
  endtask

  task automatic host_op(input logic we, input logic [0:0] sel, input logic [AW-1:0] a,
                         input logic [255:0] wd, input logic [255:0] exp, input int busy_cyc);
    host_mem_req   = 1'b1;
    host_mem_we    = we;
    host_mem_sel   = sel;
    host_mem_addr  = a;
    host_mem_wdata = wd;
    for (int i = 0; i < busy_cyc; i++) begin
      @(negedge clk);
      check("host_gnt_stall", {255'd0, host_mem_gnt}, 256'd0);
    end
    @(negedge clk);
    check("host_gnt", {255'd0, host_mem_gnt}, 256'd1);
    if (!we) begin
      hq.push_back(exp);
      host_issue = 1'b1;
    end
    @(posedge clk);
    #1;
    host_issue   = 1'b0;
    host_mem_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    xlr_mem_rd     = '0;
    xlr_mem_wr     = '0;
    xlr_mem_addr   = '0;
    xlr_mem_wdata  = '0;
    xlr_mem_be     = '0;
    host_mem_req   = 1'b1;
    host_mem_we    = 1'b0;
    host_mem_sel   = '0;
    host_mem_addr  = '0;
    host_mem_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt",        {255'd0, host_mem_gnt},    256'd0);
    check("rst_xlr_rdata",  xlr_mem_rdata,             256'd0);
    check("rst_host_rdata", host_mem_rdata,            256'd0);
    check("rst_rvalid",     {255'd0, host_mem_rvalid}, 256'd0);
    host_mem_req = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    #1;

    // Full write then read-after-write.
    xlr_cycle(1'b0, 1'b1, 4'd3, {32{8'hA5}}, '1, '0);
    xlr_cycle(1'b1, 1'b0, 4'd3, '0, '0, {32{8'hA5}});
    // Partial byte-enable write.
    xlr_cycle(1'b0, 1'b1, 4'd1, {32{8'h11}}, '1, '0);
    xlr_cycle(1'b0, 1'b1, 4'd1, {32{8'hFF}}, 32'h0000_000F, '0);
    xlr_cycle(1'b1, 1'b0, 4'd1, '0, '0, {{28{8'h11}}, {4{8'hFF}}});
    // Same-cycle read+write is read-first; be=0 write is a no-op.
    xlr_cycle(1'b0, 1'b1, 4'd5, {32{8'h22}}, '1, '0);
    xlr_cycle(1'b1, 1'b1, 4'd5, {32{8'h33}}, '1, {32{8'h22}});
    xlr_cycle(1'b1, 1'b0, 4'd5, '0, '0, {32{8'h33}});
    xlr_cycle(1'b0, 1'b1, 4'd5, {32{8'hEE}}, 32'h0, '0);
    xlr_cycle(1'b1, 1'b0, 4'd5, '0, '0, {32{8'h33}});
    repeat (2) @(posedge clk);
    #1;
    check("xlr_rdata_hold", xlr_mem_rdata, {32{8'h33}});

    // Host read stalled three cycles behind accelerator reads.
    xlr_cycle(1'b0, 1'b1, 4'd2, {32{8'h5A}}, '1, '0);
    fork
      begin
        for (int i = 0; i < 3; i++) xlr_cycle(1'b1, 1'b0, 4'd3, '0, '0, {32{8'hA5}});
      end
      host_op(1'b0, 1'b0, 4'd2, '0, {32{8'h5A}}, 3);
    join

    // Out-of-range select: immediate grant, zero data, writes discarded.
    fork
      xlr_cycle(1'b1, 1'b0, 4'd3, '0, '0, {32{8'hA5}});
      host_op(1'b0, 1'b1, 4'd3, '0, '0, 0);
    join
    host_op(1'b1, 1'b1, 4'd3, {32{8'hDE}}, '0, 0);
    xlr_cycle(1'b1, 1'b0, 4'd3, '0, '0, {32{8'hA5}});

    // Host write, then back-to-back host reads, then accelerator sees host data.
    host_op(1'b1, 1'b0, 4'd4, {32{8'h77}}, '0, 0);
    host_op(1'b0, 1'b0, 4'd4, '0, {32{8'h77}}, 0);
    host_op(1'b0, 1'b0, 4'd2, '0, {32{8'h5A}}, 0);
    xlr_cycle(1'b1, 1'b0, 4'd4, '0, '0, {32{8'h77}});

    // Reset during a granted host read drops it; contents survive.
    host_mem_req  = 1'b1;
    host_mem_we   = 1'b0;
    host_mem_sel  = 1'b0;
    host_mem_addr = 4'd4;
    @(negedge clk);
    check("host_gnt_pre_rst", {255'd0, host_mem_gnt}, 256'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    host_mem_req = 1'b0;
    @(negedge clk);
    check("mid_rst_host_rdata", host_mem_rdata, 256'd0);
    check("mid_rst_xlr_rdata",  xlr_mem_rdata,  256'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    xlr_cycle(1'b1, 1'b0, 4'd3, '0, '0, {32{8'hA5}});
    host_op(1'b0, 1'b0, 4'd4, '0, {32{8'h77}}, 0);

`ifdef XLR_MEM_PARITY_EN
    dut.g_mem[0].u_ram.r_mem[3][0] = ~dut.g_mem[0].u_ram.r_mem[3][0];
    xlr_cycle(1'b1, 1'b0, 4'd3, '0, '0, {{31{8'hA5}}, 8'hA4});
    check("parity_err_pulse", {{(256-NM-1){1'b0}}, parity_err}, 256'd1);
    @(posedge clk);
    #1;
    check("parity_err_clear", {{(256-NM-1){1'b0}}, parity_err}, 256'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("xlr_queue_drained",  256'(xq.size()), 256'd0);
    check("host_queue_drained", 256'(hq.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
